// File: rtl/ppu_cpu_regs.sv
// CPU-side PPU register window: control/mask/scroll state, OAM, PPUDATA buffering and vblank/NMI.
// Accesses commit on the rising edge of the cs_i cycle; VRAM strobes follow one cycle later.
module ppu_cpu_regs #(
    parameter int OAM_DEPTH = 256,
    parameter int VRAM_AW   = 14
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cs_i,
    input  logic [2:0]         addr_i,
    input  logic               rw_i,
    input  logic [7:0]         data_i,
    output logic [7:0]         data_o,
    output logic               nmi_o,
    input  logic               vblank_set_i,
    input  logic               vblank_clr_i,
    input  logic               spr0_hit_i,
    input  logic               spr_ovf_i,
    output logic [VRAM_AW-1:0] vram_addr_o,
    output logic               vram_rd_o,
    output logic               vram_wr_o,
    output logic [7:0]         vram_wdata_o,
    input  logic [7:0]         vram_rdata_i,
    input  logic [7:0]         oam_raddr_i,
    output logic [7:0]         oam_rdata_o,
    output logic [7:0]         ctrl_o,
    output logic [7:0]         mask_o,
    output logic [14:0]        t_o,
    output logic [2:0]         fine_x_o
);

    logic [7:0]         ctrl, mask, oamaddr, rd_buf, io_latch, wdata_q;
    logic [14:0]        v, t;
    logic [2:0]         x;
    logic               w, vblank_flag;
    logic               vram_rd, vram_wr, fill_pend;
    logic [VRAM_AW-1:0] acc_addr;
    logic [7:0]         oam [OAM_DEPTH];

    logic        wr, rd, rd_status, rd_data, wr_data, wr_oam;
    logic [14:0] v_inc;

    assign wr        = cs_i & rw_i;
    assign rd        = cs_i & ~rw_i;
    // Register N of the window is selected by addr_i = N-1.
    assign rd_status = rd & (addr_i == 3'd1);
    assign rd_data   = rd & (addr_i == 3'd6);
    assign wr_data   = wr & (addr_i == 3'd6);
    assign wr_oam    = wr & (addr_i == 3'd3);
    assign v_inc     = ctrl[2] ? 15'd32 : 15'd1;

    always_comb begin
        data_o = io_latch;
        if (rd) begin
            case (addr_i)
                3'd1:    data_o = {vblank_flag & ~vblank_set_i, spr0_hit_i, spr_ovf_i, io_latch[4:0]};
                3'd3:    data_o = oam[oamaddr];
                3'd6:    data_o = rd_buf;
                default: data_o = io_latch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl        <= '0;
            mask        <= '0;
            oamaddr     <= '0;
            v           <= '0;
            t           <= '0;
            x           <= '0;
            w           <= 1'b0;
            rd_buf      <= '0;
            io_latch    <= '0;
            wdata_q     <= '0;
            vblank_flag <= 1'b0;
            vram_rd     <= 1'b0;
            vram_wr     <= 1'b0;
            fill_pend   <= 1'b0;
            acc_addr    <= '0;
        end else begin
            vram_rd   <= rd_data;
            vram_wr   <= wr_data;
            fill_pend <= vram_rd;
            if (fill_pend)
                rd_buf <= vram_rdata_i;

            // Strobe address is the pre-increment v, held while v moves on.
            if (rd_data | wr_data) begin
                acc_addr <= v[VRAM_AW-1:0];
                v        <= v + v_inc;
            end
            if (wr_data)
                wdata_q <= data_i;

            if (wr) begin
                io_latch <= data_i;
                case (addr_i)
                    3'd0: begin
                        ctrl       <= data_i;
                        t[11:10]   <= data_i[1:0];
                    end
                    3'd1: mask    <= data_i;
                    3'd2: oamaddr <= data_i;
                    3'd3: oamaddr <= oamaddr + 8'd1;
                    3'd4: begin
                        if (!w) begin
                            t[4:0] <= data_i[7:3];
                            x      <= data_i[2:0];
                            w      <= 1'b1;
                        end else begin
                            t[14:12] <= data_i[2:0];
                            t[9:5]   <= data_i[7:3];
                            w        <= 1'b0;
                        end
                    end
                    3'd5: begin
                        if (!w) begin
                            t[13:8] <= data_i[5:0];
                            t[14]   <= 1'b0;
                            w       <= 1'b1;
                        end else begin
                            t[7:0] <= data_i;
                            v      <= {t[14:8], data_i};
                            w      <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end

            if (rd_status)
                w <= 1'b0;

            // A status read racing the set pulse wins, so the set is lost.
            if (vblank_clr_i)
                vblank_flag <= 1'b0;
            else if (rd_status)
                vblank_flag <= 1'b0;
            else if (vblank_set_i)
                vblank_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_oam)
            oam[oamaddr] <= data_i;
    end

    assign oam_rdata_o  = oam[oam_raddr_i];
    assign nmi_o        = vblank_flag & ctrl[7];
    assign vram_rd_o    = vram_rd;
    assign vram_wr_o    = vram_wr;
    assign vram_wdata_o = wdata_q;
    assign vram_addr_o  = (vram_rd | vram_wr) ? acc_addr : v[VRAM_AW-1:0];
    assign ctrl_o       = ctrl;
    assign mask_o       = mask;
    assign t_o          = t;
    assign fine_x_o     = x;

endmodule

// File: tb/tb_ppu_cpu_regs.sv
// Bench for ppu_cpu_regs: register effects checked directly, VRAM strobes via a scoreboard queue.
module tb_ppu_cpu_regs;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs_i = 1'b0;
    logic [2:0]  addr_i = '0;
    logic        rw_i = 1'b0;
    logic [7:0]  data_i = '0;
    logic [7:0]  data_o;
    logic        nmi_o;
    logic        vblank_set_i = 1'b0;
    logic        vblank_clr_i = 1'b0;
    logic        spr0_hit_i = 1'b0;
    logic        spr_ovf_i = 1'b0;
    logic [13:0] vram_addr_o;
    logic        vram_rd_o, vram_wr_o;
    logic [7:0]  vram_wdata_o;
    logic [7:0]  vram_rdata_i = '0;
    logic [7:0]  oam_raddr_i = '0;
    logic [7:0]  oam_rdata_o, ctrl_o, mask_o;
    logic [14:0] t_o;
    logic [2:0]  fine_x_o;

    int tests = 0;
    int fails = 0;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [13:0] addr;
        logic [7:0]  wd;
    } exp_t;
    exp_t sb[$];

    ppu_cpu_regs dut (
        .clk(clk), .rst(rst), .cs_i(cs_i), .addr_i(addr_i), .rw_i(rw_i),
        .data_i(data_i), .data_o(data_o), .nmi_o(nmi_o),
        .vblank_set_i(vblank_set_i), .vblank_clr_i(vblank_clr_i),
        .spr0_hit_i(spr0_hit_i), .spr_ovf_i(spr_ovf_i),
        .vram_addr_o(vram_addr_o), .vram_rd_o(vram_rd_o), .vram_wr_o(vram_wr_o),
        .vram_wdata_o(vram_wdata_o), .vram_rdata_i(vram_rdata_i),
        .oam_raddr_i(oam_raddr_i), .oam_rdata_o(oam_rdata_o),
        .ctrl_o(ctrl_o), .mask_o(mask_o), .t_o(t_o), .fine_x_o(fine_x_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic rw, input logic [2:0] a, input logic [7:0] d, output logic [7:0] rdata);
        @(negedge clk);
        cs_i = 1'b1; rw_i = rw; addr_i = a; data_i = d;
        #1 rdata = data_o;
        @(posedge clk);
        #1 cs_i = 1'b0; rw_i = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        bus(1'b1, a, d, dummy);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (vram_rd_o || vram_wr_o) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_rd", vram_rd_o, e.rd);
                check("strobe_wr", vram_wr_o, e.wr);
                check("strobe_addr", vram_addr_o, e.addr);
                if (e.wr) check("strobe_wdata", vram_wdata_o, e.wd);
            end
        end
    end

    initial begin
        logic [7:0] r;
        idle(3);
        @(negedge clk) rst = 1'b0;
        idle(1);

        check("rst_nmi", nmi_o, 0);
        check("rst_vram_rd", vram_rd_o, 0);
        check("rst_vram_wr", vram_wr_o, 0);
        check("rst_ctrl", ctrl_o, 0);
        check("rst_t", t_o, 0);
        check("rst_x", fine_x_o, 0);
        check("rst_v", vram_addr_o, 0);
        bus(1'b0, 3'd1, 8'h00, r);
        check("rst_status", r, 8'h00);

        // PPUADDR then PPUDATA writes, +1 and +32 increments
        wr(3'd1, 8'h1E);
        check("mask", mask_o, 8'h1E);
        wr(3'd5, 8'h21);
        wr(3'd5, 8'h08);
        check("t_addr", t_o, 15'h2108);
        check("v_addr", vram_addr_o, 14'h2108);
        sb.push_back('{rd: 1'b0, wr: 1'b1, addr: 14'h2108, wd: 8'h5A});
        wr(3'd6, 8'h5A);
        idle(2);
        check("v_inc1", vram_addr_o, 14'h2109);
        wr(3'd0, 8'h04);
        check("ctrl", ctrl_o, 8'h04);
        sb.push_back('{rd: 1'b0, wr: 1'b1, addr: 14'h2109, wd: 8'h77});
        wr(3'd6, 8'h77);
        idle(2);
        check("v_inc32", vram_addr_o, 14'h2129);

        // Buffered PPUDATA reads
        wr(3'd0, 8'h00);
        wr(3'd5, 8'h21);
        wr(3'd5, 8'h08);
        vram_rdata_i = 8'hAB;
        sb.push_back('{rd: 1'b1, wr: 1'b0, addr: 14'h2108, wd: 8'h00});
        bus(1'b0, 3'd6, 8'h00, r);
        check("rdbuf_first", r, 8'h00);
        idle(3);
        vram_rdata_i = 8'hCD;
        sb.push_back('{rd: 1'b1, wr: 1'b0, addr: 14'h2109, wd: 8'h00});
        bus(1'b0, 3'd6, 8'h00, r);
        check("rdbuf_second", r, 8'hAB);
        idle(3);
        check("v_after_reads", vram_addr_o, 14'h210A);
        bus(1'b0, 3'd0, 8'h00, r);
        check("io_latch_read", r, 8'h08);

        // Vblank, NMI, status read side effects
        @(negedge clk) vblank_set_i = 1'b1;
        @(posedge clk) #1 vblank_set_i = 1'b0;
        check("nmi_masked", nmi_o, 0);
        wr(3'd0, 8'h80);
        check("nmi_on_ctrl", nmi_o, 1);
        wr(3'd4, 8'h7D);
        spr0_hit_i = 1'b1;
        bus(1'b0, 3'd1, 8'h00, r);
        check("status_vbl", r, 8'hDD);
        check("nmi_after_status", nmi_o, 0);
        wr(3'd4, 8'h00);
        check("w_cleared", fine_x_o, 3'd0);
        wr(3'd4, 8'h00);
        spr0_hit_i = 1'b0;
        spr_ovf_i = 1'b1;
        vblank_set_i = 1'b1;
        bus(1'b0, 3'd1, 8'h00, r);
        vblank_set_i = 1'b0;
        check("status_race", r, 8'h20);
        check("nmi_race", nmi_o, 0);
        bus(1'b0, 3'd1, 8'h00, r);
        check("status_suppressed", r, 8'h20);
        spr_ovf_i = 1'b0;
        @(negedge clk) vblank_set_i = 1'b1;
        @(posedge clk) #1 vblank_set_i = 1'b0;
        check("nmi_set", nmi_o, 1);
        @(negedge clk) begin vblank_set_i = 1'b1; vblank_clr_i = 1'b1; end
        @(posedge clk) #1 begin vblank_set_i = 1'b0; vblank_clr_i = 1'b0; end
        check("clr_wins", nmi_o, 0);

        // OAM writes wrapping at $FF, DMA-style spacing
        wr(3'd2, 8'hFE);
        wr(3'd3, 8'h11);
        idle(1);
        wr(3'd3, 8'h22);
        idle(1);
        wr(3'd3, 8'h33);
        wr(3'd3, 8'h44);
        oam_raddr_i = 8'hFE; #1 check("oam_fe", oam_rdata_o, 8'h11);
        oam_raddr_i = 8'hFF; #1 check("oam_ff", oam_rdata_o, 8'h22);
        oam_raddr_i = 8'h00; #1 check("oam_00", oam_rdata_o, 8'h33);
        oam_raddr_i = 8'h01; #1 check("oam_01", oam_rdata_o, 8'h44);
        wr(3'd2, 8'hFF);
        bus(1'b0, 3'd3, 8'h00, r);
        check("oam_rd", r, 8'h22);
        bus(1'b0, 3'd3, 8'h00, r);
        check("oam_rd_noinc", r, 8'h22);

        // Scroll writes and nametable select
        bus(1'b0, 3'd1, 8'h00, r);
        wr(3'd4, 8'h7D);
        wr(3'd4, 8'h5E);
        check("t_scroll", t_o, 15'h616F);
        check("x_scroll", fine_x_o, 3'd5);
        wr(3'd0, 8'h03);
        check("t_nt", t_o, 15'h6D6F);

        // Reset while a PPUDATA read fill is pending
        sb.push_back('{rd: 1'b1, wr: 1'b0, addr: 14'h210A, wd: 8'h00});
        bus(1'b0, 3'd6, 8'h00, r);
        check("rd_before_rst", r, 8'hCD);
        vram_rdata_i = 8'hEE;
        @(negedge clk) rst = 1'b1;
        @(posedge clk) #1 rst = 1'b0;
        check("rst2_ctrl", ctrl_o, 0);
        check("rst2_mask", mask_o, 0);
        check("rst2_t", t_o, 0);
        check("rst2_x", fine_x_o, 0);
        check("rst2_v", vram_addr_o, 0);
        check("rst2_nmi", nmi_o, 0);
        idle(3);
        sb.push_back('{rd: 1'b1, wr: 1'b0, addr: 14'h0000, wd: 8'h00});
        bus(1'b0, 3'd6, 8'h00, r);
        check("rst2_rdbuf", r, 8'h00);
        idle(4);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
